// File: rtl/soc_l2_bank_arbiter.sv
// Round-robin arbiter sharing one single-cycle-latency L2 slave port between TCDM masters.
// Escalates starving requesters, holds the grant across slave stalls, and routes each response back.
module soc_l2_bank_arbiter #(
  parameter int NR_MASTERS = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 15
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NR_MASTERS-1:0]            m_req_i,
  input  logic [NR_MASTERS*ADDR_WIDTH-1:0] m_add_i,
  input  logic [NR_MASTERS-1:0]            m_wen_i,
  input  logic [NR_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
  input  logic [NR_MASTERS*DATA_WIDTH/8-1:0] m_be_i,
  output logic [NR_MASTERS-1:0]            m_gnt_o,
  output logic [NR_MASTERS-1:0]            m_r_valid_o,
  output logic [DATA_WIDTH-1:0]            m_r_rdata_o,
  output logic                             mem_req_o,
  output logic [ADDR_WIDTH-1:0]            mem_add_o,
  output logic                             mem_wen_o,
  output logic [DATA_WIDTH-1:0]            mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]          mem_be_o,
  input  logic                             mem_gnt_i,
  input  logic                             mem_r_valid_i,
  input  logic [DATA_WIDTH-1:0]            mem_r_rdata_i,
  output logic                             err_o
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = (NR_MASTERS > 1) ? $clog2(NR_MASTERS) : 1;
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {ARB, HOLD} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] rr_q;
  logic [IDX_W-1:0] sel_q;
  logic [IDX_W-1:0] resp_idx_q;
  logic             resp_pend_q;
  logic             err_q;
  logic [CNT_W-1:0] wait_q [NR_MASTERS];

  logic             starve_found;
  logic [IDX_W-1:0] starve_idx;
  logic [IDX_W-1:0] rr_idx;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] winner_next;
  logic             hs;

  // Starving requesters beat the round-robin pointer; lowest starving index first.
  always_comb begin
    starve_found = 1'b0;
    starve_idx   = '0;
    rr_idx       = '0;
    for (int i = NR_MASTERS - 1; i >= 0; i--) begin
      if (m_req_i[i] && (wait_q[i] == CNT_W'(MAX_WAIT))) begin
        starve_found = 1'b1;
        starve_idx   = IDX_W'(i);
      end
    end
    for (int k = NR_MASTERS - 1; k >= 0; k--) begin
      int j;
      j = (int'(rr_q) + k) % NR_MASTERS;
      if (m_req_i[j]) rr_idx = IDX_W'(j);
    end
    if (state_q == HOLD)   winner = sel_q;
    else if (starve_found) winner = starve_idx;
    else                   winner = rr_idx;
    winner_next = (int'(winner) == NR_MASTERS - 1) ? '0 : winner + IDX_W'(1);
  end

  assign mem_req_o   = (|m_req_i) & ~rst_i;
  assign hs          = mem_req_o & mem_gnt_i;
  assign mem_add_o   = m_add_i[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
  assign mem_wen_o   = m_wen_i[winner];
  assign mem_wdata_o = m_wdata_i[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
  assign mem_be_o    = m_be_i[int'(winner)*BE_W +: BE_W];
  assign m_gnt_o     = hs ? (NR_MASTERS'(1) << winner) : '0;
  assign m_r_valid_o = (mem_r_valid_i & resp_pend_q & ~rst_i) ? (NR_MASTERS'(1) << resp_idx_q) : '0;
  assign m_r_rdata_o = mem_r_rdata_i;
  assign err_o       = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ARB;
      rr_q        <= '0;
      sel_q       <= '0;
      resp_idx_q  <= '0;
      resp_pend_q <= 1'b0;
      err_q       <= 1'b0;
      for (int i = 0; i < NR_MASTERS; i++) wait_q[i] <= '0;
    end else begin
      case (state_q)
        ARB: begin
          if (hs) begin
            rr_q <= winner_next;
          end else if (mem_req_o) begin
            sel_q   <= winner;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (hs) begin
            rr_q    <= winner_next;
            state_q <= ARB;
          end
        end
        default: state_q <= ARB;
      endcase

      resp_pend_q <= hs;
      if (hs) resp_idx_q <= winner;
      // A response with nothing outstanding is dropped and flagged until reset.
      if (mem_r_valid_i && !resp_pend_q) err_q <= 1'b1;

      for (int i = 0; i < NR_MASTERS; i++) begin
        if (m_req_i[i] && !m_gnt_o[i]) begin
          if (wait_q[i] != CNT_W'(MAX_WAIT)) wait_q[i] <= wait_q[i] + CNT_W'(1);
        end else begin
          wait_q[i] <= '0;
        end
      end
    end
  end

endmodule
